// File: rtl/bit_serializer_pkg.sv
// Shared state encodings for the serializer and the downstream "10010" detector.
package bit_serializer_pkg;

    // Serializer control states
    typedef enum logic [1:0] {
        SER_IDLE  = 2'b00,
        SER_SHIFT = 2'b01,
        SER_GAP   = 2'b10
    } ser_state_t;

    // Detector progress through "10010"; DET_S5 means the full pattern was just seen
    typedef enum logic [2:0] {
        DET_S0 = 3'd0,
        DET_S1 = 3'd1,
        DET_S2 = 3'd2,
        DET_S3 = 3'd3,
        DET_S4 = 3'd4,
        DET_S5 = 3'd5
    } det_state_t;

    // Width of the inter-word gap counter (GAP up to 15)
    localparam int GAP_CW = 4;

endpackage

// File: rtl/seq_detector_10010.sv
// Moore detector for the overlapping serial pattern "10010"; y is high for the
// cycle after the final 0 of the pattern has been sampled.
module seq_detector_10010
    import bit_serializer_pkg::*;
(
    input  logic ck,
    input  logic rs,
    input  logic s,
    output logic y
);

    det_state_t state;
    det_state_t state_nxt;

    // State register with asynchronous active-low reset
    always_ff @(posedge ck or negedge rs) begin
        if (!rs) begin
            state <= DET_S0;
        end else begin
            state <= state_nxt;
        end
    end

    // Pattern progress; on a break fall back to the longest matching suffix
    always_comb begin
        state_nxt = DET_S0;
        case (state)
            DET_S0:  state_nxt = s ? DET_S1 : DET_S0;
            DET_S1:  state_nxt = s ? DET_S1 : DET_S2;
            DET_S2:  state_nxt = s ? DET_S1 : DET_S3;
            DET_S3:  state_nxt = s ? DET_S4 : DET_S0;
            DET_S4:  state_nxt = s ? DET_S1 : DET_S5;
            DET_S5:  state_nxt = s ? DET_S1 : DET_S3;
            default: state_nxt = DET_S0;
        endcase
    end

    assign y = (state == DET_S5);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: takes words over valid/ready and shifts them out
// one bit per clock, with an optional fixed idle gap after every word.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int GAP       = 0,
    parameter int MSB_FIRST = 1
)
(
    input  logic                      ck,
    input  logic                      rs,
    input  logic [WIDTH-1:0]          din,
    input  logic                      din_valid,
    output logic                      din_ready,
    output logic                      s_out,
    output logic                      s_valid,
    output logic                      busy,
    output logic [$clog2(WIDTH)-1:0]  bit_cnt
);

    localparam int                CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]     LAST_BIT = CW'(WIDTH - 1);
    localparam logic [GAP_CW-1:0] GAP_LOAD = (GAP > 0) ? GAP_CW'(GAP - 1) : '0;

    ser_state_t        state;
    ser_state_t        state_nxt;
    logic [WIDTH-1:0]  shreg;
    logic [WIDTH-1:0]  shreg_nxt;
    logic [WIDTH-1:0]  shifted;
    logic [CW-1:0]     cnt_nxt;
    logic [GAP_CW-1:0] gap_cnt;
    logic [GAP_CW-1:0] gap_nxt;
    logic              last_bit;
    logic              take;

    assign last_bit = (bit_cnt == LAST_BIT);
    // din_ready is decoded from registered state only, so this is not a loop
    assign take     = din_valid & din_ready;
    // The bit on s_out is always at the leaving end; shift toward it
    assign shifted  = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                       : {1'b0, shreg[WIDTH-1:1]};

    // Next-state and datapath update
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = bit_cnt;
        gap_nxt   = gap_cnt;
        case (state)
            SER_IDLE: begin
                if (take) begin
                    shreg_nxt = din;
                    cnt_nxt   = '0;
                    state_nxt = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                if (!last_bit) begin
                    shreg_nxt = shifted;
                    cnt_nxt   = bit_cnt + 1'b1;
                end else if (GAP > 0) begin
                    shreg_nxt = shifted;
                    cnt_nxt   = '0;
                    gap_nxt   = GAP_LOAD;
                    state_nxt = SER_GAP;
                end else if (take) begin
                    // Back-to-back reload: next word's first bit follows with no bubble
                    shreg_nxt = din;
                    cnt_nxt   = '0;
                end else begin
                    shreg_nxt = shifted;
                    cnt_nxt   = '0;
                    state_nxt = SER_IDLE;
                end
            end
            SER_GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = SER_IDLE;
                end else begin
                    gap_nxt = gap_cnt - 1'b1;
                end
            end
            default: begin
                // Unused encoding: recover to IDLE
                state_nxt = SER_IDLE;
                cnt_nxt   = '0;
                gap_nxt   = '0;
            end
        endcase
    end

    // State, shift register and counters; reset discards any word in flight
    always_ff @(posedge ck or negedge rs) begin
        if (!rs) begin
            state   <= SER_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= cnt_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    // Moore output decode from registered state only
    always_comb begin
        s_out     = 1'b0;
        s_valid   = 1'b0;
        din_ready = 1'b0;
        busy      = (state != SER_IDLE);
        case (state)
            SER_IDLE: begin
                din_ready = 1'b1;
            end
            SER_SHIFT: begin
                s_valid   = 1'b1;
                s_out     = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
                din_ready = (GAP == 0) && last_bit;
            end
            default: begin
                din_ready = 1'b0;
            end
        endcase
    end

endmodule
